// File: rtl/ay_bus_pkg.sv
// Shared types for the AY-3-8910 bus sequencer: FSM states, {bdir,bc1} bus codes
// and the decode from bus code to one-hot pseudo-command.
package ay_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP1,
        ST_WR,
        ST_RD,
        ST_GAP2,
        ST_DONE
    } state_t;

    localparam logic [1:0] INACT = 2'b00;
    localparam logic [1:0] LADDR = 2'b11;
    localparam logic [1:0] WRPSG = 2'b10;
    localparam logic [1:0] RDPSG = 2'b01;

    // One-hot ordering is {rdpsg, wrpsg, laddr, inact}.
    function automatic logic [3:0] cmd_onehot(input logic [1:0] cmd);
        logic [3:0] oh;
        case (cmd)
            LADDR:   oh = 4'b0010;
            WRPSG:   oh = 4'b0100;
            RDPSG:   oh = 4'b1000;
            default: oh = 4'b0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ay_rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester not served last wins.
module ay_rr_arb2 (
    input  logic       clk,
    input  logic       nreset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    logic last_r1;

    always_comb begin
        gnt = 2'b00;
        if (grant_en) begin
            if (req == 2'b11) begin
                gnt = last_r1 ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Starting as "r1 served last" makes r0 win the first contention after reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            last_r1 <= 1'b1;
        end else if (|gnt) begin
            last_r1 <= gnt[1];
        end
    end

endmodule

// File: rtl/ay_bus_seq.sv
// AY-3-8910 PSG bus-cycle sequencer: arbitrates two register-level requesters and
// drives BDIR/BC1 plus the data bus through LADDR/WRPSG/RDPSG phases.
module ay_bus_seq
    import ay_bus_pkg::*;
#(
    parameter int T_ADDR     = 4,
    parameter int T_GAP      = 2,
    parameter int T_WR       = 4,
    parameter int T_RD       = 4,
    parameter int CNT_W      = 4,
    parameter bit ADDR_CACHE = 1'b1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       r0_req,
    input  logic       r0_we,
    input  logic [3:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic       r0_ack,
    input  logic       r1_req,
    input  logic       r1_we,
    input  logic [3:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic       r1_ack,
    output logic [7:0] rdata,
    output logic       ay_bdir,
    output logic       ay_bc1,
    output logic [7:0] ay_da_out,
    output logic       ay_da_oe,
    input  logic [7:0] ay_da_in,
    output logic       ay_inact,
    output logic       ay_laddr,
    output logic       ay_wrpsg,
    output logic       ay_rdpsg
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (T_ADDR < 1 || T_ADDR > CNT_MAX) begin : g_bad_t_addr
        $error("ay_bus_seq: T_ADDR out of range for CNT_W");
    end
    if (T_GAP < 1 || T_GAP > CNT_MAX) begin : g_bad_t_gap
        $error("ay_bus_seq: T_GAP out of range for CNT_W");
    end
    if (T_WR < 1 || T_WR > CNT_MAX) begin : g_bad_t_wr
        $error("ay_bus_seq: T_WR out of range for CNT_W");
    end
    if (T_RD < 1 || T_RD > CNT_MAX) begin : g_bad_t_rd
        $error("ay_bus_seq: T_RD out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(T_ADDR);
    localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(T_GAP);
    localparam logic [CNT_W-1:0] LD_WR   = CNT_W'(T_WR);
    localparam logic [CNT_W-1:0] LD_RD   = CNT_W'(T_RD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             cnt_last;

    logic [3:0] lat_addr;
    logic       lat_we;
    logic [7:0] lat_wdata;
    logic       sel_r1;

    logic       cache_valid;
    logic [3:0] cache_addr;

    logic [1:0] gnt;
    logic       grant;
    logic [3:0] g_addr;
    logic       g_we;
    logic [7:0] g_wdata;
    logic       hit;
    logic [1:0] cmd;

    ay_rr_arb2 u_arb (
        .clk      (clk),
        .nreset   (nreset),
        .req      ({r1_req, r0_req}),
        .grant_en (state == ST_IDLE),
        .gnt      (gnt)
    );

    assign grant    = |gnt;
    assign g_addr   = gnt[1] ? r1_addr  : r0_addr;
    assign g_we     = gnt[1] ? r1_we    : r0_we;
    assign g_wdata  = gnt[1] ? r1_wdata : r0_wdata;
    assign hit      = ADDR_CACHE && cache_valid && (cache_addr == g_addr);
    assign cnt_last = (cnt == ONE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    if (!hit) begin
                        state_nx = ST_ADDR;
                        cnt_nx   = LD_ADDR;
                    end else if (g_we) begin
                        state_nx = ST_WR;
                        cnt_nx   = LD_WR;
                    end else begin
                        state_nx = ST_RD;
                        cnt_nx   = LD_RD;
                    end
                end
            end
            ST_ADDR: begin
                if (cnt_last) begin
                    state_nx = ST_GAP1;
                    cnt_nx   = LD_GAP;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            ST_GAP1: begin
                if (cnt_last) begin
                    state_nx = lat_we ? ST_WR : ST_RD;
                    cnt_nx   = lat_we ? LD_WR : LD_RD;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            ST_WR, ST_RD: begin
                if (cnt_last) begin
                    state_nx = ST_GAP2;
                    cnt_nx   = LD_GAP;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            ST_GAP2: begin
                if (cnt_last) begin
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request fields are captured once at grant so requesters may change them afterwards.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            sel_r1    <= 1'b0;
        end else if (state == ST_IDLE && grant) begin
            lat_addr  <= g_addr;
            lat_we    <= g_we;
            lat_wdata <= g_wdata;
            sel_r1    <= gnt[1];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
        end else if (state == ST_ADDR && cnt_last) begin
            cache_valid <= 1'b1;
            cache_addr  <= lat_addr;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata <= '0;
        end else if (state == ST_RD && cnt_last) begin
            rdata <= ay_da_in;
        end
    end

    // Bus outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        cmd       = INACT;
        ay_da_out = 8'h00;
        ay_da_oe  = 1'b0;
        r0_ack    = 1'b0;
        r1_ack    = 1'b0;
        case (state)
            ST_ADDR: begin
                cmd       = LADDR;
                ay_da_out = {4'h0, lat_addr};
                ay_da_oe  = 1'b1;
            end
            ST_GAP1: begin
                ay_da_out = {4'h0, lat_addr};
                ay_da_oe  = 1'b1;
            end
            ST_WR: begin
                cmd       = WRPSG;
                ay_da_out = lat_wdata;
                ay_da_oe  = 1'b1;
            end
            ST_RD: begin
                cmd = RDPSG;
            end
            ST_GAP2: begin
                ay_da_out = lat_we ? lat_wdata : 8'h00;
                ay_da_oe  = lat_we;
            end
            ST_DONE: begin
                r0_ack = !sel_r1;
                r1_ack = sel_r1;
            end
            default: ;
        endcase
    end

    assign {ay_bdir, ay_bc1} = cmd;
    assign {ay_rdpsg, ay_wrpsg, ay_laddr, ay_inact} = cmd_onehot(cmd);

endmodule

// File: tb/tb_ay_bus_seq.sv
// Scoreboard bench for ay_bus_seq: stimulus queues expected completions, monitors
// check bus phases and acks against them.
module tb_ay_bus_seq;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [3:0] r0_addr = 0, r1_addr = 0;
    logic [7:0] r0_wdata = 0, r1_wdata = 0, ay_da_in = 0;
    logic       r0_ack, r1_ack, ay_bdir, ay_bc1, ay_da_oe;
    logic [7:0] rdata, ay_da_out;
    logic       ay_inact, ay_laddr, ay_wrpsg, ay_rdpsg;

    logic       b_req = 0, b_ack, b_r1_ack, b_bdir, b_bc1, b_oe;
    logic [7:0] b_rdata, b_dout;
    logic       b_inact, b_laddr, b_wrpsg, b_rdpsg;

    always #5 clk = ~clk;

    ay_bus_seq dut (
        .clk(clk), .nreset(nreset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rdata(rdata), .ay_bdir(ay_bdir), .ay_bc1(ay_bc1), .ay_da_out(ay_da_out),
        .ay_da_oe(ay_da_oe), .ay_da_in(ay_da_in), .ay_inact(ay_inact), .ay_laddr(ay_laddr),
        .ay_wrpsg(ay_wrpsg), .ay_rdpsg(ay_rdpsg)
    );

    ay_bus_seq #(.T_GAP(1), .ADDR_CACHE(1'b0)) dut_nc (
        .clk(clk), .nreset(nreset),
        .r0_req(b_req), .r0_we(1'b1), .r0_addr(4'd3), .r0_wdata(8'h99), .r0_ack(b_ack),
        .r1_req(1'b0), .r1_we(1'b0), .r1_addr(4'd0), .r1_wdata(8'h00), .r1_ack(b_r1_ack),
        .rdata(b_rdata), .ay_bdir(b_bdir), .ay_bc1(b_bc1), .ay_da_out(b_dout),
        .ay_da_oe(b_oe), .ay_da_in(8'h00), .ay_inact(b_inact), .ay_laddr(b_laddr),
        .ay_wrpsg(b_wrpsg), .ay_rdpsg(b_rdpsg)
    );

    typedef struct {
        int         id;
        int         cyc;
        int         n_la;
        int         n_wr;
        int         n_rd;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         sb2[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] rd_model = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the default-parameter DUT: tallies phases, checks drive, pops on ack.
    int   n_la = 0, n_wr = 0, n_rd = 0;
    logic bus_bad = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!nreset) begin
            n_la = 0; n_wr = 0; n_rd = 0; bus_bad = 1'b0;
        end else begin
            checkOutput("onehot", 32'($countones({ay_rdpsg, ay_wrpsg, ay_laddr, ay_inact})), 1);
            checkOutput("ack_exclusive", {31'b0, r0_ack & r1_ack}, 0);
            if (ay_inact && {ay_bdir, ay_bc1} != 2'b00) bus_bad = 1'b1;
            if (ay_laddr) begin
                n_la++;
                if (sb.size() == 0 || {ay_bdir, ay_bc1} != 2'b11 || !ay_da_oe ||
                    ay_da_out != {4'h0, sb[0].addr}) bus_bad = 1'b1;
            end
            if (ay_wrpsg) begin
                n_wr++;
                if (sb.size() == 0 || {ay_bdir, ay_bc1} != 2'b10 || !ay_da_oe ||
                    ay_da_out != sb[0].wdata) bus_bad = 1'b1;
            end
            if (ay_rdpsg) begin
                n_rd++;
                if ({ay_bdir, ay_bc1} != 2'b01 || ay_da_oe) bus_bad = 1'b1;
            end
            if (r0_ack || r1_ack) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected_ack actual=ack required=none (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("ack_id", {31'b0, r1_ack}, mon_e.id);
                    checkOutput("ack_cycle", cyc, mon_e.cyc);
                    checkOutput("laddr_cycles", n_la, mon_e.n_la);
                    checkOutput("wrpsg_cycles", n_wr, mon_e.n_wr);
                    checkOutput("rdpsg_cycles", n_rd, mon_e.n_rd);
                    checkOutput("rdata", {24'b0, rdata}, {24'b0, mon_e.rdata});
                    checkOutput("bus_drive", {31'b0, bus_bad}, 0);
                end
                n_la = 0; n_wr = 0; n_rd = 0; bus_bad = 1'b0;
            end
        end
    end

    // Monitor for the no-cache, short-gap DUT.
    int b_la = 0;
    int b_exp;
    always @(negedge clk) begin
        if (!nreset) begin
            b_la = 0;
        end else begin
            if (b_laddr) b_la++;
            if (b_ack) begin
                if (sb2.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL nc_unexpected_ack actual=ack required=none (cycle %0d)", cyc);
                end else begin
                    b_exp = sb2.pop_front();
                    checkOutput("nc_ack_cycle", cyc, b_exp);
                    checkOutput("nc_laddr_cycles", b_la, 4);
                end
                b_la = 0;
            end
        end
    end

    task automatic driveReq(input int id, input logic v);
        if (id == 0) r0_req = v; else r1_req = v;
    endtask

    task automatic applyStimulus(input int id, input logic we, input logic [3:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] din,
                                 input int lat, input int la);
        exp_t e;
        bit   got = 0;
        @(negedge clk); #1;
        if (!we) rd_model = din;
        e.id = id; e.cyc = cyc + lat; e.n_la = la;
        e.n_wr = we ? 4 : 0; e.n_rd = we ? 0 : 4;
        e.addr = addr; e.wdata = wdata; e.rdata = rd_model;
        sb.push_back(e);
        ay_da_in = din;
        if (id == 0) begin r0_we = we; r0_addr = addr; r0_wdata = wdata; end
        else         begin r1_we = we; r1_addr = addr; r1_wdata = wdata; end
        driveReq(id, 1'b1);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            if (r0_ack || r1_ack) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("[TB] FAIL ack_timeout actual=none required=ack id=%0d", id);
        end
        driveReq(id, 1'b0);
    endtask

    task automatic applyContention();
        exp_t e;
        int   n0 = 0, n1 = 0;
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            e.id = k % 2; e.cyc = cyc + 13 + 14 * k; e.n_la = 4; e.n_wr = 4; e.n_rd = 0;
            e.addr = (k % 2 == 0) ? 4'd1 : 4'd2;
            e.wdata = (k % 2 == 0) ? 8'h11 : 8'h22;
            e.rdata = rd_model;
            sb.push_back(e);
        end
        r0_we = 1; r0_addr = 4'd1; r0_wdata = 8'h11;
        r1_we = 1; r1_addr = 4'd2; r1_wdata = 8'h22;
        r0_req = 1; r1_req = 1;
        for (int i = 0; i < 200 && (n0 < 2 || n1 < 2); i++) begin
            @(negedge clk); #1;
            if (r0_ack) begin n0++; if (n0 == 2) r0_req = 0; end
            if (r1_ack) begin n1++; if (n1 == 2) r1_req = 0; end
        end
        checkOutput("contention_acks", n0 * 16 + n1, 2 * 16 + 2);
        r0_req = 0; r1_req = 0;
    endtask

    task automatic applyNoCache();
        bit got = 0;
        @(negedge clk); #1;
        sb2.push_back(cyc + 11);
        b_req = 1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            if (b_ack) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("[TB] FAIL nc_ack_timeout actual=none required=ack");
        end
        b_req = 0;
    endtask

    initial begin
        #1;
        checkOutput("rst_bus", {29'b0, ay_bdir, ay_bc1, ay_da_oe}, 0);
        checkOutput("rst_da_out", {24'b0, ay_da_out}, 0);
        checkOutput("rst_acks", {30'b0, r0_ack, r1_ack}, 0);
        checkOutput("rst_rdata", {24'b0, rdata}, 0);
        checkOutput("rst_cmd", {28'b0, ay_rdpsg, ay_wrpsg, ay_laddr, ay_inact}, 4'b0001);
        repeat (2) @(negedge clk);
        #1 nreset = 1;

        applyStimulus(0, 1, 4'd7,  8'h38, 8'h00, 13, 4);
        applyStimulus(0, 1, 4'd7,  8'h3F, 8'h00, 7,  0);
        applyStimulus(0, 1, 4'd8,  8'h55, 8'h00, 13, 4);
        applyStimulus(1, 0, 4'd14, 8'h00, 8'hAB, 13, 4);
        applyStimulus(1, 1, 4'd14, 8'h11, 8'h00, 7,  0);
        checkOutput("rdata_held", {24'b0, rdata}, 32'hAB);
        applyContention();

        // Reset in the middle of a write phase.
        @(negedge clk); #1;
        r0_we = 1; r0_addr = 4'd7; r0_wdata = 8'h5A; r0_req = 1;
        for (int i = 0; i < 40 && !ay_wrpsg; i++) begin
            @(negedge clk); #1;
        end
        checkOutput("reached_wrpsg", {31'b0, ay_wrpsg}, 1);
        nreset = 0;
        #1;
        checkOutput("midrst_bus", {29'b0, ay_bdir, ay_bc1, ay_da_oe}, 0);
        checkOutput("midrst_cmd", {28'b0, ay_rdpsg, ay_wrpsg, ay_laddr, ay_inact}, 4'b0001);
        checkOutput("midrst_rdata", {24'b0, rdata}, 0);
        r0_req = 0;
        rd_model = 8'h00;
        repeat (2) @(negedge clk);
        #1 nreset = 1;
        applyStimulus(0, 1, 4'd7, 8'h5A, 8'h00, 13, 4);

        applyNoCache();
        applyNoCache();

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("nc_sb_drained", sb2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
